// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : serial_adder_ctrl                                               |
// | Desc   : Bit-serial adder: one full-adder slice over WIDTH cycles, LSB   |
// |          first, start/done handshake. Optional subtract mode is built   |
// |          in when SERIAL_ADDER_SUB_EN is defined.                         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int                CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               cy_q, cy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic               w_s;
    logic               w_cy;

    // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_c_load = i_sub ? 1'b1 : i_c;
`else
    assign w_b_load = i_b;
    assign w_c_load = i_c;
`endif

    assign w_s  = a_sr_q[0] ^ b_sr_q[0] ^ cy_q;
    assign w_cy = (a_sr_q[0] & b_sr_q[0]) | (cy_q & (a_sr_q[0] ^ b_sr_q[0]));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        cy_d     = cy_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_sr_d  = i_a;
                    b_sr_d  = w_b_load;
                    cy_d    = w_c_load;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {w_s, sum_sr_q[WIDTH-1:1]};
                cy_d     = w_cy;
                cnt_d    = cnt_q + C_CNT_ONE;
                if (cnt_q == C_CNT_LAST) begin
                    sum_d   = {w_s, sum_sr_q[WIDTH-1:1]};
                    carry_d = w_cy;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            cy_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            cy_q     <= cy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_sum   = sum_q;
    assign o_carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_serial_adder_ctrl                                            |
// | Desc   : Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_serial_adder_ctrl;

    typedef struct {
        int value;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    logic       start8 = 1'b0, c8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;

    logic       start2 = 1'b0, c2 = 1'b0, sub2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, carry2;
    logic [1:0] sum2;

    exp_t       q8[$];
    exp_t       q2[$];
    int         last8 = 0;
    int         last2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(sub8),
`endif
        .i_a(a8), .i_b(b8), .i_c(c8),
        .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(carry8)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(sub2),
`endif
        .i_a(a2), .i_b(b2), .i_c(c2),
        .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_carry(carry2)
    );

    // {carry,sum} as one integer: carry sits at bit w.
    function automatic int model(int w, int a, int b, int c, int sub);
        int m;
        m = 1 << w;
        if (sub != 0)
            return ((a - b + m) % m) + ((a >= b) ? m : 0);
        return a + b + c;
    endfunction

    task automatic check(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop on every o_done, otherwise the result must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done8) begin
                if (q8.size() == 0) begin
                    check("w8_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("w8_result", int'({carry8, sum8}), e.value);
                    check("w8_done_cycle", cyc, e.due);
                    last8 = e.value;
                end
            end else begin
                check("w8_hold", int'({carry8, sum8}), last8);
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    check("w2_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("w2_result", int'({carry2, sum2}), e.value);
                    check("w2_done_cycle", cyc, e.due);
                    last2 = e.value;
                end
            end else begin
                check("w2_hold", int'({carry2, sum2}), last2);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input int a, input int b, input int c, input int sub);
        int guard;
        exp_t e;
        guard = 0;
        while (busy8 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("w8_idle_timeout", guard, 0);
        a8 = a[7:0]; b8 = b[7:0]; c8 = c[0]; sub8 = sub[0]; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        e.value = model(8, a, b, c, sub);
`else
        e.value = model(8, a, b, c, 0);
`endif
        e.due = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic issue2(input int a, input int b, input int c);
        int guard;
        exp_t e;
        guard = 0;
        while (busy2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("w2_idle_timeout", guard, 0);
        a2 = a[1:0]; b2 = b[1:0]; c2 = c[0]; sub2 = 1'b0; start2 = 1'b1;
        e.value = model(2, a, b, c, 0);
        e.due = cyc + 1 + 2;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy8 || busy2 || q8.size() != 0 || q2.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", guard, 0);
    endtask

    initial begin
        int nb;
        #1;
        check("reset_outputs8", int'({busy8, done8, carry8, sum8}), 0);
        check("reset_outputs2", int'({busy2, done2, carry2, sum2}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with busy-length check
        issue8(8'h5A, 8'h3C, 0, 0);
        nb = 0;
        while (busy8 && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        check("w8_busy_cycles", nb, 9);
        wait_idle();

        issue8(8'hFF, 8'h01, 0, 0);
        issue8(8'hFF, 8'hFF, 1, 0);
        wait_idle();

        // Start while busy is ignored; monitor rejects a second done
        issue8(8'h12, 8'h34, 1, 0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation
        issue8(8'hA5, 8'h5A, 1, 0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        last8 = 0;
        #1;
        check("w8_abort_outputs", int'({busy8, done8, carry8, sum8}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue8(8'h80, 8'h80, 1, 0);
        wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
        issue8(8'h10, 8'h01, 0, 1);
        issue8(8'h01, 8'h02, 1, 1);
        wait_idle();
`endif

        // WIDTH=2 exhaustive
        for (int i = 0; i < 32; i++) issue2(i & 3, (i >> 2) & 3, (i >> 4) & 1);
        wait_idle();

        // Randomised WIDTH=8, back-to-back
        for (int i = 0; i < 150; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            issue8(int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(1)), int'($urandom_range(1)));
`else
            issue8(int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(1)), 0);
`endif
        end
        wait_idle();
        repeat (4) @(negedge clk);
        check("w8_queue_empty", q8.size(), 0);
        check("w2_queue_empty", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
